tdm_demux_1to4: RTL and testbench
=================================

TDM_DEMUX_1TO4 -- requirements
Module: tdm_demux_1to4

Interface
REQ-001 Parameter: WIDTH, default 1, bit width of each channel sample.
REQ-002 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 Port: rst_n  input  1  reset, asynchronous and active-low.
REQ-004 Port: din  input  WIDTH  time-multiplexed sample stream.
REQ-005 Port: in_valid  input  1  din is a valid sample this cycle.
REQ-006 Port: sync  input  1  marks the current valid sample as slot 0 of a frame.
REQ-007 Port: err_clr  input  1  clears sync_err.
REQ-008 Port: ch0, ch1, ch2, ch3  output  WIDTH each  registered demultiplexed channel outputs.
REQ-009 Port: frame_valid  output  1  one-cycle pulse when ch0..ch3 update.
REQ-010 Port: slot  output  2  slot index that the next valid sample will fill.
REQ-011 Port: frame_cnt  output  8  count of completed frames.
REQ-012 Port: sync_err  output  1  sticky flag for a sync received mid-frame.

Function
REQ-013 The block SHALL hold a 2-bit slot counter and three WIDTH-bit shadow registers for slots 0..2.
REQ-014 Cycle with in_valid=0: counter, shadows and outputs SHALL hold; frame_valid SHALL be 0; sync is ignored.
REQ-015 Cycle with in_valid=1 and sync=1: din SHALL be written to shadow 0 and the counter SHALL become 1, whatever its prior value.
REQ-016 Cycle with in_valid=1, sync=0 and counter in 0..2: din SHALL be written to shadow[counter], and the counter SHALL increment.
REQ-017 Cycle with in_valid=1, sync=0 and counter=3: on the next edge, ch0..ch2 SHALL load shadows 0..2, ch3 SHALL load din, frame_valid SHALL be 1, the counter SHALL wrap to 0, and frame_cnt SHALL increment.
REQ-018 Latency from the slot-3 sample to the ch3 update and the frame_valid pulse SHALL be exactly 1 clock.
REQ-019 frame_valid SHALL be 1 for exactly one cycle per completed frame and 0 otherwise.
REQ-020 ch0..ch3 SHALL change only on frame_valid cycles and hold between frames.
REQ-021 frame_cnt SHALL wrap from 255 to 0.
REQ-022 slot SHALL equal the counter value at all times.
REQ-023 A sync with in_valid=1 while the counter is nonzero SHALL discard the partial frame without updating any output except sync_err.
REQ-024 A frame completes only after four consecutive valid slots; gaps with in_valid=0 are permitted between slots.

Reset
REQ-025 While rst_n=0, regardless of clk: counter=0, shadows=0, ch0..ch3=0, frame_valid=0, frame_cnt=0, sync_err=0.
REQ-026 Reset asserted mid-frame SHALL discard the partial frame; the first valid sample after release fills slot 0 even without sync.

Configuration
REQ-027 Macro TDM_DEMUX_SYNC_ERR_EN defined: sync_err SHALL set on the REQ-023 condition and stay set until err_clr=1 or reset.
REQ-028 With TDM_DEMUX_SYNC_ERR_EN defined, if set and clear occur in the same cycle, set SHALL win.
REQ-029 Macro TDM_DEMUX_SYNC_ERR_EN undefined: sync_err SHALL be tied to 0 and err_clr ignored; all other behaviour is unchanged.

Verification
REQ-030 WIDTH=1; valid samples 0,1,0,1, with sync on the first -> one cycle after the 4th sample ch0..ch3=0,1,0,1, frame_valid pulses once, frame_cnt=1.
REQ-031 Same frame with in_valid=0 for 3 cycles between slots 1 and 2 -> identical outputs; slot holds at 2 during the gap; no early frame_valid.
REQ-032 Slots 0,1 valid (values 1,1), then sync with din=0 -> slot=1, outputs unchanged, and sync_err=1 when the macro is defined (0 when undefined); err_clr -> sync_err=0.
REQ-033 256 complete frames -> frame_cnt returns to 0 and frame_valid pulses 256 times.
REQ-034 rst_n pulled low after 2 slots of a frame -> all outputs 0 immediately; the next 4 valid samples without sync form a full frame.
REQ-035 WIDTH=4; frame 4'hA,4'h5,4'hC,4'h3 -> ch0=A, ch1=5, ch2=C, ch3=3 one cycle after the last sample.

Source files
------------

// File: rtl/tdm_demux_1to4.sv
// tdm_demux_1to4 : 1-to-4 time-division demultiplexer.
// Valid samples are collected into slots 0..2 shadow registers; the slot-3
// sample completes the frame and all four channels update together, with a
// one-cycle frame_valid pulse and a wrapping 8-bit frame counter.
// Optional feature: define TDM_DEMUX_SYNC_ERR_EN to enable the sticky
// sync_err flag (sync seen mid-frame); otherwise sync_err is tied low.
module tdm_demux_1to4 #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] din,
    input  logic             in_valid,
    input  logic             sync,
    input  logic             err_clr,
    output logic [WIDTH-1:0] ch0,
    output logic [WIDTH-1:0] ch1,
    output logic [WIDTH-1:0] ch2,
    output logic [WIDTH-1:0] ch3,
    output logic             frame_valid,
    output logic [1:0]       slot,
    output logic [7:0]       frame_cnt,
    output logic             sync_err
);

    logic [1:0]       cnt_reg;
    logic [1:0]       cnt_next;
    logic [WIDTH-1:0] shadow_reg [3];
    logic [WIDTH-1:0] ch_reg [4];
    logic             frame_valid_reg;
    logic [7:0]       frame_cnt_reg;

    // A sync sample always restarts the frame at slot 0; a plain sample
    // either fills the current slot or, in slot 3, completes the frame.
    logic sync_sample;
    logic data_sample;
    logic frame_done;

    assign sync_sample = in_valid & sync;
    assign data_sample = in_valid & ~sync;
    assign frame_done  = data_sample & (cnt_reg == 2'd3);

    // Next slot: sync forces slot 1, a plain sample advances (3 wraps to 0).
    always_comb begin
        cnt_next = cnt_reg;
        if (sync_sample) begin
            cnt_next = 2'd1;
        end else if (data_sample) begin
            cnt_next = cnt_reg + 2'd1;
        end
    end

    // Slot counter register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_reg <= 2'd0;
        end else begin
            cnt_reg <= cnt_next;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_shadow
            // Capture the sample for this slot; sync always lands in shadow 0.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    shadow_reg[gi] <= '0;
                end else if ((sync_sample && (gi == 0)) ||
                             (data_sample && (cnt_reg == 2'(gi)))) begin
                    shadow_reg[gi] <= din;
                end
            end
        end

        for (gi = 0; gi < 4; gi++) begin : g_ch
            if (gi < 3) begin : g_from_shadow
                // Channels 0..2 publish their shadow when the frame completes.
                always_ff @(posedge clk or negedge rst_n) begin
                    if (!rst_n) begin
                        ch_reg[gi] <= '0;
                    end else if (frame_done) begin
                        ch_reg[gi] <= shadow_reg[gi];
                    end
                end
            end else begin : g_from_din
                // Channel 3 takes the completing sample directly.
                always_ff @(posedge clk or negedge rst_n) begin
                    if (!rst_n) begin
                        ch_reg[gi] <= '0;
                    end else if (frame_done) begin
                        ch_reg[gi] <= din;
                    end
                end
            end
        end
    endgenerate

    // Frame pulse and completed-frame counter (8-bit, wraps naturally).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_valid_reg <= 1'b0;
            frame_cnt_reg   <= 8'd0;
        end else begin
            frame_valid_reg <= frame_done;
            if (frame_done) begin
                frame_cnt_reg <= frame_cnt_reg + 8'd1;
            end
        end
    end

`ifdef TDM_DEMUX_SYNC_ERR_EN
    logic sync_err_reg;
    logic mid_sync;

    assign mid_sync = sync_sample & (cnt_reg != 2'd0);

    // Sticky error: a mid-frame sync sets it and wins over a simultaneous clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_err_reg <= 1'b0;
        end else if (mid_sync) begin
            sync_err_reg <= 1'b1;
        end else if (err_clr) begin
            sync_err_reg <= 1'b0;
        end
    end

    assign sync_err = sync_err_reg;
`else
    logic unused_err_clr;
    assign unused_err_clr = err_clr;
    assign sync_err       = 1'b0;
`endif

    assign ch0         = ch_reg[0];
    assign ch1         = ch_reg[1];
    assign ch2         = ch_reg[2];
    assign ch3         = ch_reg[3];
    assign frame_valid = frame_valid_reg;
    assign slot        = cnt_reg;
    assign frame_cnt   = frame_cnt_reg;

endmodule

// File: tb/tb_tdm_demux_1to4.sv
// Bench for tdm_demux_1to4: a WIDTH=4 and a WIDTH=1 instance share the same
// control stream (the narrow one sees din[0]); a queue-based frame model is
// checked every cycle, plus literal expectations for the directed scenarios.
module tb_tdm_demux_1to4;

`ifdef TDM_DEMUX_SYNC_ERR_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] din = 4'd0;
    logic       in_valid = 1'b0;
    logic       sync = 1'b0;
    logic       err_clr = 1'b0;

    logic [3:0] c4_0, c4_1, c4_2, c4_3;
    logic       fv4, err4;
    logic [1:0] slot4;
    logic [7:0] fcnt4;
    logic       c1_0, c1_1, c1_2, c1_3;
    logic       fv1, err1;
    logic [1:0] slot1;
    logic [7:0] fcnt1;
    logic       din1;

    assign din1 = din[0];

    tdm_demux_1to4 #(.WIDTH(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .din(din), .in_valid(in_valid),
        .sync(sync), .err_clr(err_clr),
        .ch0(c4_0), .ch1(c4_1), .ch2(c4_2), .ch3(c4_3),
        .frame_valid(fv4), .slot(slot4), .frame_cnt(fcnt4), .sync_err(err4)
    );

    tdm_demux_1to4 #(.WIDTH(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .din(din1), .in_valid(in_valid),
        .sync(sync), .err_clr(err_clr),
        .ch0(c1_0), .ch1(c1_1), .ch2(c1_2), .ch3(c1_3),
        .frame_valid(fv1), .slot(slot1), .frame_cnt(fcnt1), .sync_err(err1)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int pulses = 0;
    bit run_cmp = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h time=%0t", nm, act, exp, $time);
        end
    endtask

    // Model: samples of the frame in progress, the last published frame,
    // the pulse, the frame count and the sticky error.
    logic [3:0] q[$];
    logic [3:0] m_ch [4] = '{default: 4'd0};
    bit         m_fv = 1'b0;
    int         m_fcnt = 0;
    bit         m_err = 1'b0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q.delete();
            m_ch   = '{default: 4'd0};
            m_fv   = 1'b0;
            m_fcnt = 0;
            m_err  = 1'b0;
        end else begin
            bit set_now;
            set_now = ERR_EN && in_valid && sync && (q.size() != 0);
            m_fv = 1'b0;
            if (in_valid) begin
                if (sync) begin
                    q.delete();
                    q.push_back(din);
                end else begin
                    q.push_back(din);
                    if (q.size() == 4) begin
                        for (int i = 0; i < 4; i++) m_ch[i] = q[i];
                        m_fv   = 1'b1;
                        m_fcnt = (m_fcnt + 1) % 256;
                        q.delete();
                    end
                end
            end
            if (set_now) m_err = 1'b1;
            else if (ERR_EN && err_clr) m_err = 1'b0;
        end
    end

    // Per-cycle compare against the model, away from the active edge.
    always @(negedge clk) begin
        if (run_cmp) begin
            chk("w4_ch0", 32'(c4_0), 32'(m_ch[0]));
            chk("w4_ch1", 32'(c4_1), 32'(m_ch[1]));
            chk("w4_ch2", 32'(c4_2), 32'(m_ch[2]));
            chk("w4_ch3", 32'(c4_3), 32'(m_ch[3]));
            chk("w1_ch0", 32'(c1_0), 32'(m_ch[0][0]));
            chk("w1_ch1", 32'(c1_1), 32'(m_ch[1][0]));
            chk("w1_ch2", 32'(c1_2), 32'(m_ch[2][0]));
            chk("w1_ch3", 32'(c1_3), 32'(m_ch[3][0]));
            chk("w4_fv", 32'(fv4), 32'(m_fv));
            chk("w1_fv", 32'(fv1), 32'(m_fv));
            chk("w4_slot", 32'(slot4), 32'(q.size()));
            chk("w1_slot", 32'(slot1), 32'(q.size()));
            chk("w4_fcnt", 32'(fcnt4), 32'(m_fcnt));
            chk("w1_fcnt", 32'(fcnt1), 32'(m_fcnt));
            chk("w4_err", 32'(err4), 32'(m_err));
            chk("w1_err", 32'(err1), 32'(m_err));
            if (fv4) pulses++;
        end
    end

    // One clock with the given inputs; returns 1 time unit after that edge.
    task automatic smp(input bit v, input bit s, input logic [3:0] d, input bit c = 1'b0);
        @(negedge clk);
        #1;
        in_valid = v;
        sync     = s;
        din      = d;
        err_clr  = c;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        sync     = 1'b0;
        err_clr  = 1'b0;
        $display("txn v=%0d sync=%0d din=%0h clr=%0d -> slot=%0d fv=%0d fcnt=%0d err=%0d",
                 v, s, d, c, slot4, fv4, fcnt4, err4);
    endtask

    task automatic chk_all_zero(input string nm);
        chk({nm, "_ch"}, {c4_0, c4_1, c4_2, c4_3, 12'd0, c1_0, c1_1, c1_2, c1_3}, 32'd0);
        chk({nm, "_fv"}, 32'({fv4, fv1}), 32'd0);
        chk({nm, "_slot"}, 32'({slot4, slot1}), 32'd0);
        chk({nm, "_fcnt"}, 32'({fcnt4, fcnt1}), 32'd0);
        chk({nm, "_err"}, 32'({err4, err1}), 32'd0);
    endtask

    initial begin
        int p0;
        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk_all_zero("reset");
        @(negedge clk);
        #1;
        rst_n = 1'b1;
        run_cmp = 1'b1;

        // Basic frame 0,1,0,1 with sync on the first sample
        smp(1, 1, 4'd0); smp(1, 0, 4'd1); smp(1, 0, 4'd0); smp(1, 0, 4'd1);
        chk("t1_w1_ch", 32'({c1_0, c1_1, c1_2, c1_3}), 32'b0101);
        chk("t1_w4_ch", {16'd0, c4_0, c4_1, c4_2, c4_3}, 32'h0101);
        chk("t1_fv", 32'(fv4), 32'd1);
        chk("t1_fcnt", 32'(fcnt1), 32'd1);
        @(posedge clk); #1;
        chk("t1_fv_drop", 32'({fv4, fv1}), 32'd0);

        // Same frame with a 3-cycle gap between slots 1 and 2
        smp(1, 1, 4'd0); smp(1, 0, 4'd1);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            chk("t2_gap_slot", 32'(slot4), 32'd2);
            chk("t2_gap_fv", 32'(fv4), 32'd0);
        end
        smp(1, 0, 4'd0); smp(1, 0, 4'd1);
        chk("t2_w1_ch", 32'({c1_0, c1_1, c1_2, c1_3}), 32'b0101);
        chk("t2_fcnt", 32'(fcnt4), 32'd2);

        // Mid-frame sync, error clear, then set-wins-over-clear
        smp(1, 1, 4'd1); smp(1, 0, 4'd1); smp(1, 1, 4'd0);
        chk("t3_slot", 32'(slot1), 32'd1);
        chk("t3_ch_hold", 32'({c1_0, c1_1, c1_2, c1_3}), 32'b0101);
        chk("t3_fcnt", 32'(fcnt1), 32'd2);
        chk("t3_err", 32'(err1), 32'(ERR_EN));
        smp(0, 0, 4'd0, 1'b1);
        chk("t3_err_clr", 32'(err1), 32'd0);
        smp(1, 1, 4'd7, 1'b1);
        chk("t3_set_wins", 32'(err4), 32'(ERR_EN));
        chk("t3_slot2", 32'(slot4), 32'd1);
        smp(1, 0, 4'd2); smp(1, 0, 4'd3); smp(1, 0, 4'd4);
        chk("t3_w4_ch", {16'd0, c4_0, c4_1, c4_2, c4_3}, 32'h7234);
        chk("t3_fcnt2", 32'(fcnt4), 32'd3);

        // WIDTH=4 frame A,5,C,3
        smp(1, 1, 4'hA); smp(1, 0, 4'h5); smp(1, 0, 4'hC); smp(1, 0, 4'h3);
        chk("t4_w4_ch", {16'd0, c4_0, c4_1, c4_2, c4_3}, 32'hA5C3);
        chk("t4_fcnt", 32'(fcnt4), 32'd4);

        // Reset mid-frame, then a frame without sync
        smp(1, 1, 4'h9); smp(1, 0, 4'h6);
        @(negedge clk); #1;
        rst_n = 1'b0;
        #1;
        chk_all_zero("t5_async");
        @(negedge clk); #1;
        rst_n = 1'b1;
        smp(1, 0, 4'h1); smp(1, 0, 4'h2); smp(1, 0, 4'h3); smp(1, 0, 4'h4);
        chk("t5_w4_ch", {16'd0, c4_0, c4_1, c4_2, c4_3}, 32'h1234);
        chk("t5_fcnt", 32'(fcnt4), 32'd1);

        // 256 frames from reset: counter wraps back to 0
        @(negedge clk); #1;
        rst_n = 1'b0;
        @(negedge clk); #1;
        rst_n = 1'b1;
        p0 = pulses;
        for (int f = 0; f < 256; f++) begin
            for (int s = 0; s < 4; s++) begin
                smp(1, (s == 0) && (f % 2 == 1), 4'($urandom_range(0, 15)));
            end
        end
        @(posedge clk); #1;
        chk("t6_fcnt_wrap", 32'({fcnt4, fcnt1}), 32'd0);
        @(negedge clk); #1;
        chk("t6_pulses", 32'(pulses - p0), 32'd256);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
